// File: rtl/rgb_pwm_pkg.sv
// Shared constants, types and helpers for the RGB PWM controller.
package rgb_pwm_pkg;

  localparam int PWM_W = 8;

  localparam logic [2:0] ADDR_CTRL   = 3'd0;
  localparam logic [2:0] ADDR_DUTY0  = 3'd1;
  localparam logic [2:0] ADDR_DUTY1  = 3'd2;
  localparam logic [2:0] ADDR_DUTY2  = 3'd3;
  localparam logic [2:0] ADDR_PRESC  = 3'd4;
  localparam logic [2:0] ADDR_RATE   = 3'd5;
  localparam logic [2:0] ADDR_STATUS = 3'd6;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_BREATHE = 1;

  // Direction of the breathing envelope; this is the envelope's whole
  // state machine and is visible to software through STATUS bit 8.
  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } breathe_dir_e;

  // Scale a duty by the envelope level: 8x8 product, keep the top byte.
  function automatic logic [PWM_W-1:0] scale_duty(input logic [PWM_W-1:0] duty,
                                                  input logic [PWM_W-1:0] level);
    logic [2*PWM_W-1:0] prod;
    prod = duty * level;
    return prod[2*PWM_W-1:PWM_W];
  endfunction

endpackage

// File: rtl/rgb_pwm_ctrl_if.sv
// Peripheral bus seen by the RGB PWM controller.
// Handshake: an access happens on every clk edge where cs is high; cs & we
// is a write of din to register addr, cs & !we is a read whose data appears
// on dout one cycle later and is held until the next read. There is no
// wait state and no back-pressure.
interface rgb_pwm_ctrl_if;
  logic        cs;
  logic        we;
  logic [2:0]  addr;
  logic [31:0] din;
  logic [31:0] dout;

  modport master (output cs, output we, output addr, output din, input dout);
  modport slave  (input cs, input we, input addr, input din, output dout);
endinterface

// File: rtl/rgb_pwm_chan.sv
// One PWM channel: period-boundary duty shadow, optional envelope scaling
// and the registered compare that drives the LED driver input.
module rgb_pwm_chan
  import rgb_pwm_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_en,
  input  logic             i_load,
  input  logic             i_breathe,
  input  logic [PWM_W-1:0] i_duty,
  input  logic [PWM_W-1:0] i_level,
  input  logic [PWM_W-1:0] i_cnt,
  output logic             o_pwm
);

  logic [PWM_W-1:0] r_shadow;
  logic             r_pwm;
  logic [PWM_W-1:0] w_eff;

  assign w_eff = i_breathe ? scale_duty(r_shadow, i_level) : r_shadow;
  assign o_pwm = r_pwm;

  // Shadow the duty at period boundaries and register the compare result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shadow <= '0;
      r_pwm    <= 1'b0;
    end else begin
      if (i_load) begin
        r_shadow <= i_duty;
      end
      r_pwm <= i_en & (i_cnt < w_eff);
    end
  end

endmodule

// File: rtl/rgb_pwm_ctrl.sv
// Memory-mapped 3-channel PWM controller for the RGB LED driver, with a
// tick prescaler, glitch-free duty updates and a triangular breathing
// envelope.
module rgb_pwm_ctrl
  import rgb_pwm_pkg::*;
#(
  parameter int PRESC_W = 16,
  parameter int RATE_W  = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  rgb_pwm_ctrl_if.slave        bus,
  output logic [2:0]           pwm_o,
  output logic                 period_strobe
);

  logic               r_en;
  logic               r_breathe;
  logic [PWM_W-1:0]   r_duty [3];
  logic [PRESC_W-1:0] r_presc;
  logic [RATE_W-1:0]  r_rate;
  logic [31:0]        r_dout;

  logic [PRESC_W-1:0] r_pcnt;
  logic [PWM_W-1:0]   r_cnt;
  logic [RATE_W-1:0]  r_rcnt;
  logic [PWM_W-1:0]   r_level;
  breathe_dir_e       r_dir;
  logic               r_strobe;

  logic               w_tick;
  logic               w_wrap;
  logic               w_step;
  logic               w_shadow_load;
  logic [31:0]        w_rdata;
  logic [2:0]         w_pwm;

  // Counters only run while enabled, so tick is gated by en.
  assign w_tick        = r_en & (r_pcnt == r_presc);
  assign w_wrap        = w_tick & (r_cnt == {PWM_W{1'b1}});
  assign w_step        = w_wrap & r_breathe & (r_rcnt == r_rate);
  assign w_shadow_load = w_wrap | ~r_en;

  // Register writes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_en      <= 1'b0;
      r_breathe <= 1'b0;
      r_duty[0] <= '0;
      r_duty[1] <= '0;
      r_duty[2] <= '0;
      r_presc   <= '0;
      r_rate    <= '0;
    end else if (bus.cs && bus.we) begin
      case (bus.addr)
        ADDR_CTRL: begin
          r_en      <= bus.din[CTRL_EN];
          r_breathe <= bus.din[CTRL_BREATHE];
        end
        ADDR_DUTY0: r_duty[0] <= bus.din[PWM_W-1:0];
        ADDR_DUTY1: r_duty[1] <= bus.din[PWM_W-1:0];
        ADDR_DUTY2: r_duty[2] <= bus.din[PWM_W-1:0];
        ADDR_PRESC: r_presc   <= bus.din[PRESC_W-1:0];
        ADDR_RATE:  r_rate    <= bus.din[RATE_W-1:0];
        default: ;
      endcase
    end
  end

  // Read data mux; unused bits and the reserved address read as zero.
  always_comb begin
    w_rdata = '0;
    case (bus.addr)
      ADDR_CTRL: begin
        w_rdata[CTRL_EN]      = r_en;
        w_rdata[CTRL_BREATHE] = r_breathe;
      end
      ADDR_DUTY0:  w_rdata[PWM_W-1:0]   = r_duty[0];
      ADDR_DUTY1:  w_rdata[PWM_W-1:0]   = r_duty[1];
      ADDR_DUTY2:  w_rdata[PWM_W-1:0]   = r_duty[2];
      ADDR_PRESC:  w_rdata[PRESC_W-1:0] = r_presc;
      ADDR_RATE:   w_rdata[RATE_W-1:0]  = r_rate;
      ADDR_STATUS: begin
        w_rdata[PWM_W-1:0] = r_level;
        w_rdata[PWM_W]     = (r_dir == DIR_DOWN);
      end
      default: ;
    endcase
  end

  // Registered read port: capture on a read, hold otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dout <= '0;
    end else if (bus.cs && !bus.we) begin
      r_dout <= w_rdata;
    end
  end

  // Prescaler, PWM counter and breathing-rate counter. A PRESC written
  // below the running pcnt lets pcnt roll over at its width before ticking.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pcnt   <= '0;
      r_cnt    <= '0;
      r_rcnt   <= '0;
      r_strobe <= 1'b0;
    end else begin
      r_strobe <= w_wrap;
      if (!r_en) begin
        r_pcnt <= '0;
        r_cnt  <= '0;
        r_rcnt <= '0;
      end else begin
        r_pcnt <= w_tick ? '0 : r_pcnt + 1'b1;
        if (w_tick) begin
          r_cnt <= r_cnt + 1'b1;
        end
        if (w_wrap && r_breathe) begin
          r_rcnt <= (r_rcnt == r_rate) ? '0 : r_rcnt + 1'b1;
        end
      end
    end
  end

  // Triangular envelope: the turn-around step flips direction instead of
  // moving the level, giving 512 steps per full cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_level <= '0;
      r_dir   <= DIR_UP;
    end else if (w_step) begin
      if (r_dir == DIR_UP) begin
        if (r_level == {PWM_W{1'b1}}) r_dir <= DIR_DOWN;
        else                          r_level <= r_level + 1'b1;
      end else begin
        if (r_level == '0) r_dir <= DIR_UP;
        else               r_level <= r_level - 1'b1;
      end
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_chan
    rgb_pwm_chan u_chan (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_en      (r_en),
      .i_load    (w_shadow_load),
      .i_breathe (r_breathe),
      .i_duty    (r_duty[g]),
      .i_level   (r_level),
      .i_cnt     (r_cnt),
      .o_pwm     (w_pwm[g])
    );
  end

  assign pwm_o         = w_pwm;
  assign period_strobe = r_strobe;
  assign bus.dout      = r_dout;

endmodule

// File: tb/tb_rgb_pwm_ctrl.sv
// Directed testbench for rgb_pwm_ctrl.
module tb_rgb_pwm_ctrl;
  import rgb_pwm_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [2:0] pwm_o;
  logic       period_strobe;
  int         n_checks = 0;
  int         n_pass = 0;
  logic [31:0] exp_q[$];

  rgb_pwm_ctrl_if bus_if();

  rgb_pwm_ctrl #(.PRESC_W(16), .RATE_W(8)) u_dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .bus           (bus_if),
    .pwm_o         (pwm_o),
    .period_strobe (period_strobe)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    bus_if.cs = 1'b1; bus_if.we = 1'b1; bus_if.addr = a; bus_if.din = d;
    @(posedge clk); #1;
    bus_if.cs = 1'b0; bus_if.we = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    bus_if.cs = 1'b1; bus_if.we = 1'b0; bus_if.addr = a;
    @(posedge clk); #1;
    bus_if.cs = 1'b0;
    d = bus_if.dout;
  endtask

  task automatic wait_strobe(input int limit, input string name);
    bit found = 1'b0;
    for (int i = 0; i < limit && !found; i++) begin
      @(negedge clk);
      if (period_strobe === 1'b1) found = 1'b1;
    end
    n_checks++;
    if (!found) $display("FAIL %s: no period_strobe within %0d cycles", name, limit);
    else n_pass++;
  endtask

  // Sample n cycles on the falling edge; count high cycles per channel and strobes.
  task automatic measure(input int n, output int h0, output int h1, output int h2,
                         output int ns, output int last_pos);
    h0 = 0; h1 = 0; h2 = 0; ns = 0; last_pos = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (pwm_o[0] === 1'b1) h0++;
      if (pwm_o[1] === 1'b1) h1++;
      if (pwm_o[2] === 1'b1) h2++;
      if (period_strobe === 1'b1) begin ns++; last_pos = i; end
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    bus_write(ADDR_DUTY0, 32'h80);
    bus_write(ADDR_CTRL, 32'h1);
    repeat (40) @(posedge clk);
    #1;
    n_checks++; if (pwm_o !== 3'b001) $display("FAIL reset_pre_pwm: got %b want 001", pwm_o); else n_pass++;
    bus_read(ADDR_CTRL, rd);
    n_checks++; if (rd !== 32'h1) $display("FAIL reset_pre_ctrl: got %h want 1", rd); else n_pass++;
    #3 reset_n = 1'b0;
    #1;
    n_checks++; if (pwm_o !== 3'b000) $display("FAIL reset_pwm: got %b want 000", pwm_o); else n_pass++;
    n_checks++; if (bus_if.dout !== 32'h0) $display("FAIL reset_dout: got %h want 0", bus_if.dout); else n_pass++;
    n_checks++; if (period_strobe !== 1'b0) $display("FAIL reset_strobe: got %b want 0", period_strobe); else n_pass++;
    @(posedge clk); #3 reset_n = 1'b1;
    @(posedge clk); #1;
    for (int a = 0; a < 8; a++) begin
      bus_read(3'(a), rd);
      n_checks++;
      if (rd !== 32'h0) $display("FAIL reset_reg%0d: got %h want 0", a, rd); else n_pass++;
    end
  endtask

  task automatic test_basic_pwm();
    int h0, h1, h2, ns, lp;
    bus_write(ADDR_CTRL, 32'h0);
    bus_write(ADDR_PRESC, 32'h0);
    bus_write(ADDR_DUTY0, 32'h40);
    bus_write(ADDR_DUTY1, 32'h00);
    bus_write(ADDR_DUTY2, 32'hFF);
    bus_write(ADDR_CTRL, 32'h1);
    wait_strobe(600, "basic_first_strobe");
    measure(512, h0, h1, h2, ns, lp);
    n_checks++; if (h0 !== 128) $display("FAIL basic_duty40: got %0d want 128 high in 512", h0); else n_pass++;
    n_checks++; if (h1 !== 0)   $display("FAIL basic_duty00: got %0d want 0 high in 512", h1); else n_pass++;
    n_checks++; if (h2 !== 510) $display("FAIL basic_dutyFF: got %0d want 510 high in 512", h2); else n_pass++;
    n_checks++; if (ns !== 2)   $display("FAIL basic_strobe_cnt: got %0d want 2", ns); else n_pass++;
    n_checks++; if (lp !== 512) $display("FAIL basic_strobe_pos: got %0d want 512", lp); else n_pass++;
  endtask

  task automatic test_prescaler();
    int h0, h1, h2, ns, lp;
    bus_write(ADDR_CTRL, 32'h0);
    bus_write(ADDR_PRESC, 32'h2);
    bus_write(ADDR_DUTY0, 32'h10);
    bus_write(ADDR_DUTY1, 32'h0);
    bus_write(ADDR_DUTY2, 32'h0);
    bus_write(ADDR_CTRL, 32'h1);
    wait_strobe(1000, "presc_first_strobe");
    measure(768, h0, h1, h2, ns, lp);
    n_checks++; if (h0 !== 48)  $display("FAIL presc_high: got %0d want 48", h0); else n_pass++;
    n_checks++; if (ns !== 1)   $display("FAIL presc_strobe_cnt: got %0d want 1", ns); else n_pass++;
    n_checks++; if (lp !== 768) $display("FAIL presc_period: got %0d want 768", lp); else n_pass++;
  endtask

  task automatic test_shadowing();
    int h0, h1, h2, ns, lp;
    bus_write(ADDR_CTRL, 32'h0);
    bus_write(ADDR_PRESC, 32'h0);
    bus_write(ADDR_DUTY0, 32'h80);
    bus_write(ADDR_CTRL, 32'h1);
    wait_strobe(600, "shadow_first_strobe");
    fork
      measure(256, h0, h1, h2, ns, lp);
      begin
        repeat (99) @(posedge clk);
        #1 bus_write(ADDR_DUTY0, 32'h20);
      end
    join
    n_checks++; if (h0 !== 128) $display("FAIL shadow_mid_cur: got %0d want 128", h0); else n_pass++;
    measure(256, h0, h1, h2, ns, lp);
    n_checks++; if (h0 !== 32)  $display("FAIL shadow_mid_next: got %0d want 32", h0); else n_pass++;
    // Land the next write exactly on the wrap edge.
    repeat (255) @(posedge clk);
    #1 bus_write(ADDR_DUTY0, 32'h60);
    n_checks++; if (period_strobe !== 1'b1) $display("FAIL shadow_wrap_align: got %b want 1", period_strobe); else n_pass++;
    @(negedge clk);
    measure(256, h0, h1, h2, ns, lp);
    n_checks++; if (h0 !== 32) $display("FAIL shadow_wrap_old: got %0d want 32", h0); else n_pass++;
    measure(256, h0, h1, h2, ns, lp);
    n_checks++; if (h0 !== 96) $display("FAIL shadow_wrap_new: got %0d want 96", h0); else n_pass++;
  endtask

  task automatic test_breathing();
    int h0, h1, h2, ns, lp;
    logic [31:0] rd;
    bus_write(ADDR_CTRL, 32'h0);
    bus_write(ADDR_PRESC, 32'h0);
    bus_write(ADDR_RATE, 32'h0);
    bus_write(ADDR_DUTY0, 32'hFF);
    bus_write(ADDR_DUTY1, 32'h0);
    bus_write(ADDR_DUTY2, 32'h0);
    bus_write(ADDR_CTRL, 32'h3);
    wait_strobe(600, "breathe_strobe");
    bus_read(ADDR_STATUS, rd);
    n_checks++; if (rd !== 32'h001) $display("FAIL breathe_lvl1: got %h want 001", rd); else n_pass++;
    for (int i = 2; i <= 128; i++) wait_strobe(600, "breathe_strobe");
    measure(256, h0, h1, h2, ns, lp);
    n_checks++; if (h0 !== 127) $display("FAIL breathe_eff80: got %0d want 127", h0); else n_pass++;
    bus_read(ADDR_STATUS, rd);
    n_checks++; if (rd !== 32'h081) $display("FAIL breathe_lvl129: got %h want 081", rd); else n_pass++;
    for (int i = 130; i <= 255; i++) wait_strobe(600, "breathe_strobe");
    bus_read(ADDR_STATUS, rd);
    n_checks++; if (rd !== 32'h0FF) $display("FAIL breathe_top: got %h want 0FF", rd); else n_pass++;
    wait_strobe(600, "breathe_strobe");
    bus_read(ADDR_STATUS, rd);
    n_checks++; if (rd !== 32'h1FF) $display("FAIL breathe_flip: got %h want 1FF", rd); else n_pass++;
    wait_strobe(600, "breathe_strobe");
    bus_read(ADDR_STATUS, rd);
    n_checks++; if (rd !== 32'h1FE) $display("FAIL breathe_down: got %h want 1FE", rd); else n_pass++;
    bus_write(ADDR_CTRL, 32'h1);
    wait_strobe(600, "breathe_strobe");
    bus_read(ADDR_STATUS, rd);
    n_checks++; if (rd !== 32'h1FE) $display("FAIL breathe_hold: got %h want 1FE", rd); else n_pass++;
  endtask

  task automatic test_readback_disable();
    logic [31:0] rd;
    logic [31:0] exp;
    int n, h0;
    bit seen;
    bus_write(ADDR_CTRL,   32'hFFFF_FFFE); exp_q.push_back(32'h0000_0002);
    bus_write(ADDR_DUTY0,  32'hABCD_EF12); exp_q.push_back(32'h0000_0012);
    bus_write(ADDR_DUTY1,  32'hFFFF_FF34); exp_q.push_back(32'h0000_0034);
    bus_write(ADDR_DUTY2,  32'h1234_5656); exp_q.push_back(32'h0000_0056);
    bus_write(ADDR_PRESC,  32'hDEAD_BEEF); exp_q.push_back(32'h0000_BEEF);
    bus_write(ADDR_RATE,   32'h1234_5677); exp_q.push_back(32'h0000_0077);
    bus_write(ADDR_STATUS, 32'hFFFF_FFFF); exp_q.push_back(32'h0000_01FE);
    bus_write(3'd7,        32'hFFFF_FFFF); exp_q.push_back(32'h0000_0000);
    for (int a = 0; a < 8; a++) begin
      bus_read(3'(a), rd);
      exp = exp_q.pop_front();
      n_checks++;
      if (rd !== exp) $display("FAIL readback_reg%0d: got %h want %h", a, rd, exp); else n_pass++;
    end
    bus_read(ADDR_DUTY0, rd);
    repeat (3) @(posedge clk);
    bus_write(ADDR_DUTY1, 32'h99);
    n_checks++; if (bus_if.dout !== 32'h12) $display("FAIL readback_hold: got %h want 12", bus_if.dout); else n_pass++;

    bus_write(ADDR_CTRL, 32'h0);
    bus_write(ADDR_PRESC, 32'h0);
    bus_write(ADDR_RATE, 32'h0);
    bus_write(ADDR_DUTY0, 32'h40);
    bus_write(ADDR_DUTY1, 32'h0);
    bus_write(ADDR_DUTY2, 32'hFF);
    bus_write(ADDR_CTRL, 32'h1);
    repeat (20) @(posedge clk);
    #1;
    n_checks++; if (pwm_o !== 3'b101) $display("FAIL disable_pre: got %b want 101", pwm_o); else n_pass++;
    bus_write(ADDR_CTRL, 32'h0);
    @(posedge clk); #1;
    n_checks++; if (pwm_o !== 3'b000) $display("FAIL disable_off: got %b want 000", pwm_o); else n_pass++;
    repeat (5) @(posedge clk); #1;
    n_checks++; if (pwm_o !== 3'b000) $display("FAIL disable_stay: got %b want 000", pwm_o); else n_pass++;
    bus_write(ADDR_CTRL, 32'h1);
    n = 0; h0 = 0; seen = 1'b0;
    while (!seen && n < 600) begin
      @(negedge clk);
      n++;
      if (pwm_o[0] === 1'b1) h0++;
      if (period_strobe === 1'b1) seen = 1'b1;
    end
    n_checks++; if (n !== 257) $display("FAIL reenable_first_wrap: got %0d want 257", n); else n_pass++;
    n_checks++; if (h0 !== 64) $display("FAIL reenable_high: got %0d want 64", h0); else n_pass++;
  endtask

  // Main sequence and final report
  initial begin
    bus_if.cs = 1'b0; bus_if.we = 1'b0; bus_if.addr = '0; bus_if.din = '0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_basic_pwm();
    test_prescaler();
    test_shadowing();
    test_breathing();
    test_readback_disable();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
